// File: rtl/regfile_wb_arb_if.sv
// Write-back bus between the two write sources, the arbiter and the
// register file. The master side drives the requests and read probes;
// the slave side (the arbiter) drives the accept, the registered write
// port and the busy flags.
interface regfile_wb_arb_if;
  logic        a_valid;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy1;
  logic        busy2;

  modport master (
    output a_valid, a_waddr, a_wdata,
    output b_valid, b_waddr, b_wdata,
    output raddr1, raddr2,
    input  b_ready, we, waddr, wdata, busy1, busy2
  );

  modport slave (
    input  a_valid, a_waddr, a_wdata,
    input  b_valid, b_waddr, b_wdata,
    input  raddr1, raddr2,
    output b_ready, we, waddr, wdata, busy1, busy2
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file write-back arbiter. A fast source (ALU) always owns the
// write port; a slow source (loads, multi-cycle ops) is buffered in a
// small FIFO that drains in cycles the fast source is idle. Queued slow
// writes that are overtaken by a younger fast write to the same register
// are killed so the older value never lands. Busy flags tell the read
// side whether a register still has a write in flight.
module regfile_wb_arb #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  regfile_wb_arb_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]       count;
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [DEPTH-1:0]  q_vld;
  logic [DEPTH-1:0]  q_kill;
  logic [4:0]        q_addr [DEPTH];
  logic [31:0]       q_data [DEPTH];

  logic              full_p0;
  logic              empty_p0;
  logic              push_p0;
  logic              pop_p0;
  logic              a_hit_p0;
  logic              new_kill_p0;
  logic [DEPTH-1:0]  kill_hit_p0;

  logic              we_p1;
  logic [4:0]        waddr_p1;
  logic [31:0]       wdata_p1;

  logic              busy1_c;
  logic              busy2_c;

  // ---- stage p0: request decode, queue handshake and kill detection ----
  assign full_p0  = (count == (AW+1)'(DEPTH));
  assign empty_p0 = (count == '0);
  // Ready comes from the pre-pop occupancy so a full queue never accepts
  // in the same cycle it frees a slot.
  assign push_p0  = bus.b_valid && !full_p0;
  assign pop_p0   = !bus.a_valid && !empty_p0;
  // Only a real (non-x0) fast write can overtake queued entries.
  assign a_hit_p0 = bus.a_valid && (bus.a_waddr != 5'd0);
  assign new_kill_p0 = (bus.b_waddr == 5'd0) ||
                       (a_hit_p0 && (bus.a_waddr == bus.b_waddr));

  // Flag every queued entry whose register is overwritten by this cycle's fast write.
  always_comb begin
    kill_hit_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit_p0[i] = a_hit_p0 && q_vld[i] && (q_addr[i] == bus.a_waddr);
    end
  end

  // Queue control state: pointers, occupancy, valid and kill bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      q_vld  <= '0;
      q_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_hit_p0[i]) q_kill[i] <= 1'b1;
      end
      if (pop_p0) begin
        q_vld[head]  <= 1'b0;
        q_kill[head] <= 1'b0;
        head         <= head + AW'(1);
      end
      if (push_p0) begin
        q_vld[tail]  <= 1'b1;
        q_kill[tail] <= new_kill_p0;
        tail         <= tail + AW'(1);
      end
      case ({push_p0, pop_p0})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage; contents are qualified by q_vld so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_p0) begin
      q_addr[tail] <= bus.b_waddr;
      q_data[tail] <= bus.b_wdata;
    end
  end

  // ---- stage p1: registered register-file write port ----
  // Fast request wins; otherwise the queue head drains; otherwise idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_p1    <= 1'b0;
      waddr_p1 <= 5'd0;
      wdata_p1 <= 32'd0;
    end else if (bus.a_valid) begin
      we_p1    <= (bus.a_waddr != 5'd0);
      waddr_p1 <= bus.a_waddr;
      wdata_p1 <= bus.a_wdata;
    end else if (pop_p0) begin
      we_p1    <= !q_kill[head];
      waddr_p1 <= q_addr[head];
      wdata_p1 <= q_data[head];
    end else begin
      we_p1    <= 1'b0;
    end
  end

  // Busy probes: a live write to the register sits in the output stage or the queue.
  always_comb begin
    busy1_c = we_p1 && (waddr_p1 == bus.raddr1);
    busy2_c = we_p1 && (waddr_p1 == bus.raddr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && !q_kill[i] && (q_addr[i] == bus.raddr1)) busy1_c = 1'b1;
      if (q_vld[i] && !q_kill[i] && (q_addr[i] == bus.raddr2)) busy2_c = 1'b1;
    end
    if (bus.raddr1 == 5'd0) busy1_c = 1'b0;
    if (bus.raddr2 == 5'd0) busy2_c = 1'b0;
  end

  assign bus.b_ready = !full_p0;
  assign bus.we      = we_p1;
  assign bus.waddr   = waddr_p1;
  assign bus.wdata   = wdata_p1;
  assign bus.busy1   = busy1_c;
  assign bus.busy2   = busy2_c;

endmodule
